// File: rtl/mul_div_sequencer_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer:
// ALU opcodes, FSM state encoding and operand width.
package mul_div_sequencer_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam logic [3:0] OP_DIV = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // What the FIX state has to produce for the operation in flight
  typedef enum logic [1:0] {
    KIND_MUL,
    KIND_DIV,
    KIND_DZ,
    KIND_ILL
  } kind_t;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

endpackage

// File: rtl/mul_div_sequencer_if.sv
// Request/result bus between the control unit (master) and the
// multiply/divide sequencer (slave).
interface mul_div_sequencer_if;
  import mul_div_sequencer_pkg::*;

  logic               start;
  logic [3:0]         opcode;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2*WIDTH-1:0] ZData;
  logic               busy;
  logic               done;
  logic               div_zero;
  logic               illegal;

  modport master (
    output start, opcode, A, B,
    input  ZData, busy, done, div_zero, illegal
  );

  modport slave (
    input  start, opcode, A, B,
    output ZData, busy, done, div_zero, illegal
  );

endinterface

// File: rtl/mul_div_core.sv
// Unsigned iterative datapath: shift-add multiply (LSB first) and
// restoring divide (MSB first), one bit per enabled step.
module mul_div_core
  import mul_div_sequencer_pkg::*;
(
  input  logic               clock,
  input  logic               clear,
  input  logic               load,
  input  logic               step,
  input  logic               mode,       // 0: multiply, 1: divide
  input  logic [WIDTH-1:0]   mag_a,
  input  logic [WIDTH-1:0]   mag_b,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder
);

  logic [WIDTH-1:0]   opa;   // multiplicand, or dividend shifting out / quotient shifting in
  logic [WIDTH-1:0]   opb;   // multiplier shifting right, or divisor
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     partial;
  logic               fits;
  logic [WIDTH-1:0]   rem_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (opb[0] ? {1'b0, opa} : '0);
    partial  = {rem, opa[WIDTH-1]};
    fits     = partial >= {1'b0, opb};
    // The restored remainder is always below the divisor, so 32 bits suffice
    rem_next = partial[WIDTH-1:0] - (fits ? opb : '0);
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!clear) begin
      opa <= '0;
      opb <= '0;
      acc <= '0;
      rem <= '0;
    end else if (load) begin
      opa <= mag_a;
      opb <= mag_b;
      acc <= '0;
      rem <= '0;
    end else if (step) begin
      if (!mode) begin
        acc <= {mul_sum, acc[WIDTH-1:1]};
        opb <= opb >> 1;
      end else begin
        rem <= rem_next;
        opa <= {opa[WIDTH-2:0], fits};
      end
    end
  end

  assign product   = acc;
  assign quotient  = opa;
  assign remainder = rem;

endmodule

// File: rtl/mul_div_sequencer.sv
// Control FSM for signed 32x32 multiply and 32/32 divide: latches operands,
// runs the core for 32 steps, applies sign correction and publishes ZData.
module mul_div_sequencer
  import mul_div_sequencer_pkg::*;
(
  input  logic               clock,
  input  logic               clear,
  mul_div_sequencer_if.slave bus
);

  state_t             state, state_next;
  kind_t              kind;
  logic [CNT_W-1:0]   count;
  logic               sign_res, sign_rem;
  logic [WIDTH-1:0]   a_hold;
  logic [2*WIDTH-1:0] zdata, zdata_fixed;
  logic               div_zero_q, illegal_q;

  logic               accept, is_mul, is_div, b_zero, load;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quotient, remainder;

  assign is_mul = bus.opcode == OP_MUL;
  assign is_div = bus.opcode == OP_DIV;
  assign b_zero = bus.B == '0;
  assign accept = (state == IDLE) && bus.start;
  assign load   = accept && (is_mul || (is_div && !b_zero));

  mul_div_core u_core (
    .clock     (clock),
    .clear     (clear),
    .load      (load),
    .step      (state == CALC),
    .mode      (kind == KIND_DIV),
    .mag_a     (magnitude(bus.A)),
    .mag_b     (magnitude(bus.B)),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_ff @(posedge clock) begin
    if (!clear) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = load ? CALC : FIX;
      CALC: if (count == CNT_W'(WIDTH - 1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    zdata_fixed = '0;
    case (kind)
      KIND_MUL: zdata_fixed = sign_res ? -product : product;
      KIND_DIV: zdata_fixed = {sign_rem ? -remainder : remainder,
                               sign_res ? -quotient  : quotient};
      KIND_DZ:  zdata_fixed = {a_hold, {WIDTH{1'b1}}};
      default:  zdata_fixed = '0;
    endcase
  end

  // NOTE: the reset is synchronous, so clearing here also cancels any
  // ZData write that the aborted operation would have made.
  always_ff @(posedge clock) begin
    if (!clear) begin
      kind       <= KIND_MUL;
      count      <= '0;
      sign_res   <= 1'b0;
      sign_rem   <= 1'b0;
      a_hold     <= '0;
      zdata      <= '0;
      div_zero_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      if (accept) begin
        kind       <= is_mul ? KIND_MUL :
                      is_div ? (b_zero ? KIND_DZ : KIND_DIV) : KIND_ILL;
        count      <= '0;
        sign_res   <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
        sign_rem   <= bus.A[WIDTH-1];
        a_hold     <= bus.A;
        div_zero_q <= is_div && b_zero;
        illegal_q  <= !is_mul && !is_div;
      end
      if (state == CALC) count <= count + 1'b1;
      if (state == FIX)  zdata <= zdata_fixed;
    end
  end

  assign bus.ZData    = zdata;
  assign bus.busy     = (state == CALC) || (state == FIX);
  assign bus.done     = state == DONE;
  assign bus.div_zero = div_zero_q;
  assign bus.illegal  = illegal_q;

endmodule
